// File: rtl/sweeper_pkg.sv
// Shared types and constants for the minterm sweeper.
package sweeper_pkg;

  localparam int unsigned N_VARS_DEF = 3;
  localparam int unsigned SETTLE_DEF = 1;
  // Wide enough for SETTLE values 0..15.
  localparam int unsigned SETTLE_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSample,
    StDone
  } state_e;

  // Truth-table width for an n-input function.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-code hold counter: cleared when a new code is driven, counts up while the
// code settles, flags when the count has reached SETTLE.
module settle_timer
  import sweeper_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic term
);

  logic [SETTLE_W-1:0] cnt_q;

  // Counter register; clear has priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (incr) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Terminal flag: hold time for the current code has elapsed.
  always_comb begin
    term = (cnt_q == SETTLE_W'(SETTLE));
  end

endmodule

// File: rtl/minterm_sweeper.sv
// Drives every input code of an N_VARS-input function block in ascending
// order, captures the response into a truth table and compares it with a
// latched expected table.
module minterm_sweeper
  import sweeper_pkg::*;
#(
  parameter  int unsigned N_VARS = N_VARS_DEF,
  parameter  int unsigned SETTLE = SETTLE_DEF,
  localparam int unsigned TT_W   = tt_width(N_VARS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TT_W-1:0]   expect_i,
  input  logic              r_i,
  output logic [N_VARS-1:0] vars_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [TT_W-1:0]   table_o,
  output logic [TT_W-1:0]   mismatch_o,
  output logic              pass_o
);

  // One extra index bit so the last-code compare never aliases through a wrap.
  localparam logic [N_VARS:0] LAST_IDX = (N_VARS + 1)'(TT_W - 1);

  state_e            state_q, state_d;
  logic [N_VARS:0]   idx_q, idx_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   table_q, table_d;
  logic [TT_W-1:0]   mism_q, mism_d;
  logic              pass_q, pass_d;
  logic              tmr_clear, tmr_incr, tmr_term;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .incr  (tmr_incr),
    .term  (tmr_term)
  );

  // Next-state, capture and compare logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    exp_d     = exp_q;
    table_d   = table_q;
    mism_d    = mism_q;
    pass_d    = pass_q;
    tmr_clear = 1'b0;
    tmr_incr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          exp_d     = expect_i;
          table_d   = '0;
          mism_d    = '0;
          pass_d    = 1'b0;
          idx_d     = '0;
          tmr_clear = 1'b1;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (tmr_term) begin
          state_d = StSample;
        end else begin
          tmr_incr = 1'b1;
        end
      end
      StSample: begin
        table_d[idx_q[N_VARS-1:0]] = r_i;
        if (idx_q == LAST_IDX) begin
          // Compare against the table including the bit captured on this edge.
          mism_d  = table_d ^ exp_q;
          pass_d  = ~|(table_d ^ exp_q);
          state_d = StDone;
        end else begin
          idx_d     = idx_q + 1'b1;
          tmr_clear = 1'b1;
          state_d   = StHold;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mism_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mism_q  <= mism_d;
      pass_q  <= pass_d;
    end
  end

  // Output decode.
  always_comb begin
    vars_o     = idx_q[N_VARS-1:0];
    busy_o     = (state_q == StHold) || (state_q == StSample);
    done_o     = (state_q == StDone);
    table_o    = table_q;
    mismatch_o = mism_q;
    pass_o     = pass_q;
  end

endmodule
